// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS sequencing controller.
package mc_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StFault
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   function automatic logic op_legal(input logic [5:0] op);
      logic ok;
      case (op)
         OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
         default:                                       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. MULTICYCLE_RETIRE_COUNT_EN adds the
// retired-instruction counter.
interface multicycle_ctrl_if;

   logic       run;
   logic [5:0] OpCode;
   logic       MEM_ready;
   logic       ALU_zero;

   logic       IR_write;
   logic       PC_write;
   logic       PC_write_cond;
   logic       IorD;
   logic       MEM_read;
   logic       MEM_write;
   logic       MEM_to_reg;
   logic       REG_dst;
   logic       REG_write;
   logic       ALU_src_A;
   logic [1:0] ALU_src_B;
   logic [1:0] ALUOp;
   logic [1:0] PC_source;
   logic       busy;
   logic [1:0] fault;
`ifdef MULTICYCLE_RETIRE_COUNT_EN
   logic [31:0] retired;
`endif

   modport master (
      input  run, OpCode, MEM_ready, ALU_zero,
      output IR_write, PC_write, PC_write_cond, IorD, MEM_read, MEM_write, MEM_to_reg,
             REG_dst, REG_write, ALU_src_A, ALU_src_B, ALUOp, PC_source, busy, fault
`ifdef MULTICYCLE_RETIRE_COUNT_EN
      , output retired
`endif
   );

   modport slave (
      output run, OpCode, MEM_ready, ALU_zero,
      input  IR_write, PC_write, PC_write_cond, IorD, MEM_read, MEM_write, MEM_to_reg,
             REG_dst, REG_write, ALU_src_A, ALU_src_B, ALUOp, PC_source, busy, fault
`ifdef MULTICYCLE_RETIRE_COUNT_EN
      , input retired
`endif
   );

endinterface

// File: rtl/mc_wait_timer.sv
// Reloadable down-counter bounding memory waits; expired_o marks the Timeout-th wait cycle.
module mc_wait_timer #(
   parameter int unsigned Timeout = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CntW'(Timeout - 1);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencing controller (FETCH/DECODE/EXEC/MEM/WB) with memory-wait timeout.
// MULTICYCLE_RETIRE_COUNT_EN adds a retired-instruction counter.
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input logic               SYS_clk,
   input logic               SYS_reset,
   multicycle_ctrl_if.master bus
);

   state_e     state_q, state_d;
   logic [5:0] op_q, op_d;
   logic [1:0] fault_q, fault_d;
   logic       instr_end;
   logic       tmr_load;
   logic       tmr_expired;

   mc_wait_timer #(
      .Timeout (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk_i     (SYS_clk),
      .rst_i     (SYS_reset),
      .load_i    (tmr_load),
      .en_i      ((state_q == StFetch) || (state_q == StMem)),
      .expired_o (tmr_expired)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      fault_d   = fault_q;
      instr_end = 1'b0;

      bus.IR_write      = 1'b0;
      bus.PC_write      = 1'b0;
      bus.PC_write_cond = 1'b0;
      bus.IorD          = 1'b0;
      bus.MEM_read      = 1'b0;
      bus.MEM_write     = 1'b0;
      bus.MEM_to_reg    = 1'b0;
      bus.REG_dst       = 1'b0;
      bus.REG_write     = 1'b0;
      bus.ALU_src_A     = 1'b0;
      bus.ALU_src_B     = SRCB_REG;
      bus.ALUOp         = ALUOP_ADD;
      bus.PC_source     = PCSRC_ALU;
      bus.busy          = (state_q != StIdle) && (state_q != StFault);
      bus.fault         = fault_q;

      unique case (state_q)
         StIdle: begin
            if (bus.run) state_d = StFetch;
         end
         StFetch: begin
            bus.MEM_read  = 1'b1;
            bus.ALU_src_B = SRCB_FOUR;
            bus.IR_write  = bus.MEM_ready;
            bus.PC_write  = bus.MEM_ready;
            // Ready in the expiring cycle still completes the fetch.
            if (bus.MEM_ready) begin
               state_d = StDecode;
            end else if (tmr_expired) begin
               state_d = StFault;
               fault_d = FAULT_TIMEOUT;
            end
         end
         StDecode: begin
            bus.ALU_src_B = SRCB_IMM_SH2;
            if (op_legal(bus.OpCode)) begin
               op_d    = bus.OpCode;
               state_d = StExec;
            end else begin
               state_d = StFault;
               fault_d = FAULT_ILLEGAL;
            end
         end
         StExec: begin
            unique case (op_q)
               OP_RTYPE: begin
                  bus.ALU_src_A = 1'b1;
                  bus.ALUOp     = ALUOP_FUNCT;
                  state_d       = StWb;
               end
               OP_ADDI, OP_LW, OP_SW: begin
                  bus.ALU_src_A = 1'b1;
                  bus.ALU_src_B = SRCB_IMM;
                  state_d       = (op_q == OP_ADDI) ? StWb : StMem;
               end
               OP_BEQ: begin
                  bus.ALU_src_A     = 1'b1;
                  bus.ALUOp         = ALUOP_SUB;
                  bus.PC_write_cond = 1'b1;
                  bus.PC_source     = PCSRC_ALUOUT;
                  instr_end         = 1'b1;
               end
               default: begin
                  bus.PC_write  = 1'b1;
                  bus.PC_source = PCSRC_JUMP;
                  instr_end     = 1'b1;
               end
            endcase
         end
         StMem: begin
            bus.IorD      = 1'b1;
            bus.MEM_read  = (op_q == OP_LW);
            bus.MEM_write = (op_q == OP_SW);
            if (bus.MEM_ready) begin
               if (op_q == OP_LW) state_d = StWb;
               else               instr_end = 1'b1;
            end else if (tmr_expired) begin
               state_d = StFault;
               fault_d = FAULT_TIMEOUT;
            end
         end
         StWb: begin
            bus.REG_write  = 1'b1;
            bus.REG_dst    = (op_q == OP_RTYPE);
            bus.MEM_to_reg = (op_q == OP_LW);
            instr_end      = 1'b1;
         end
         StFault: begin
            state_d = StFault;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // run is only consulted at instruction boundaries.
      if (instr_end) state_d = bus.run ? StFetch : StIdle;

      tmr_load = (state_d != state_q) && ((state_d == StFetch) || (state_d == StMem));
   end

   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         state_q <= StIdle;
         op_q    <= '0;
         fault_q <= FAULT_NONE;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         fault_q <= fault_d;
      end
   end

`ifdef MULTICYCLE_RETIRE_COUNT_EN
   logic [31:0] retired_q, retired_d;

   always_comb begin
      retired_d = retired_q;
      if (instr_end) retired_d = retired_q + 32'd1;
   end

   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         retired_q <= '0;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign bus.retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction cycle-sequence model checked every cycle.
module tb_multicycle_ctrl;

   localparam int unsigned TO = 4;

   typedef struct packed {
      logic       ir_w;
      logic       pc_w;
      logic       pc_wc;
      logic       iord;
      logic       mrd;
      logic       mwr;
      logic       m2r;
      logic       rdst;
      logic       rwr;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       busy;
      logic [1:0] flt;
   } outv_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   outv_t exp_cur;
   outv_t act;
   outv_t zero_v;
   bit    chk_en = 1'b0;
   int    total = 0;
   int    bad = 0;
   int    busy_cycles = 0;
   int    regwr_at = 0;
   logic [31:0] ret_exp = '0;
   string phase = "reset";

   always #5 clk = ~clk;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(
      .MEM_TIMEOUT (TO)
   ) dut (
      .SYS_clk   (clk),
      .SYS_reset (rst),
      .bus       (bus)
   );

   always @(negedge clk) begin
      if (chk_en) begin
         act.ir_w  = bus.IR_write;
         act.pc_w  = bus.PC_write;
         act.pc_wc = bus.PC_write_cond;
         act.iord  = bus.IorD;
         act.mrd   = bus.MEM_read;
         act.mwr   = bus.MEM_write;
         act.m2r   = bus.MEM_to_reg;
         act.rdst  = bus.REG_dst;
         act.rwr   = bus.REG_write;
         act.srca  = bus.ALU_src_A;
         act.srcb  = bus.ALU_src_B;
         act.aluop = bus.ALUOp;
         act.pcsrc = bus.PC_source;
         act.busy  = bus.busy;
         act.flt   = bus.fault;
         total++;
         if (act !== exp_cur) begin
            bad++;
            $display("FAIL %s t=%0t outputs got=%b want=%b", phase, $time, act, exp_cur);
         end
`ifdef MULTICYCLE_RETIRE_COUNT_EN
         total++;
         if (bus.retired !== ret_exp) begin
            bad++;
            $display("FAIL %s t=%0t retired got=%0d want=%0d", phase, $time, bus.retired, ret_exp);
         end
`endif
         if (bus.busy === 1'b1) busy_cycles++;
         if (bus.REG_write === 1'b1) regwr_at = busy_cycles;
      end
   end

   task automatic step(input logic rdy, input logic rn, input outv_t e);
      bus.MEM_ready = rdy;
      bus.run       = rn;
      exp_cur       = e;
      chk_en        = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic check_lit(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // Expands one instruction into its expected per-cycle outputs, starting in FETCH.
   task automatic instr(input logic [5:0] op, input int fw, input int mw, input logic run_late,
                        input bit rst_in_mem, input int len_lit);
      outv_t e;
      int    start;
      bit    is_r, is_addi, is_lw, is_sw, is_beq, is_j;
      is_r    = (op == 6'h00);
      is_addi = (op == 6'h08);
      is_lw   = (op == 6'h23);
      is_sw   = (op == 6'h2B);
      is_beq  = (op == 6'h04);
      is_j    = (op == 6'h02);
      start   = busy_cycles;
      phase   = $sformatf("op%02h", op);
      bus.OpCode = op;

      e = '0; e.busy = 1'b1; e.mrd = 1'b1; e.srcb = 2'b01;
      repeat (fw) step(1'b0, 1'b1, e);
      e.ir_w = 1'b1; e.pc_w = 1'b1;
      step(1'b1, 1'b1, e);

      // MEM_ready high outside FETCH/MEM must have no effect.
      e = '0; e.busy = 1'b1; e.srcb = 2'b11;
      step(1'b1, 1'b1, e);

      if (!(is_r || is_addi || is_lw || is_sw || is_beq || is_j)) begin
         e = '0; e.flt = 2'b01;
         repeat (3) step(1'b1, 1'b1, e);
         check_lit("illegal_fault_code", int'(bus.fault), 1);
         check_lit("illegal_busy", int'(bus.busy), 0);
         return;
      end

      e = '0; e.busy = 1'b1; e.srca = 1'b1;
      if (is_r) e.aluop = 2'b10;
      if (is_addi || is_lw || is_sw) e.srcb = 2'b10;
      if (is_beq) begin e.aluop = 2'b01; e.pc_wc = 1'b1; e.pcsrc = 2'b01; end
      if (is_j) begin e.srca = 1'b0; e.pc_w = 1'b1; e.pcsrc = 2'b10; end
      step(1'b1, run_late, e);

      if (is_lw || is_sw) begin
         e = '0; e.busy = 1'b1; e.iord = 1'b1; e.mrd = is_lw; e.mwr = is_sw;
         if (rst_in_mem) begin
            phase = "reset_in_mem";
            rst = 1'b1;
            step(1'b0, 1'b0, e);
            rst = 1'b0;
            ret_exp = '0;
            step(1'b0, 1'b0, zero_v);
            return;
         end
         repeat (mw) step(1'b0, run_late, e);
         step(1'b1, run_late, e);
      end

      if (is_r || is_addi || is_lw) begin
         e = '0; e.busy = 1'b1; e.rwr = 1'b1; e.rdst = is_r; e.m2r = is_lw;
         step(1'b1, run_late, e);
      end

      ret_exp = ret_exp + 32'd1;
      check_lit($sformatf("len_op%02h", op), busy_cycles - start, len_lit);
   endtask

   task automatic hard_reset();
      phase = "hard_reset";
      chk_en = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ret_exp = '0;
      step(1'b0, 1'b0, zero_v);
   endtask

   initial begin
      outv_t e;
      int    s;
      zero_v        = '0;
      bus.run       = 1'b0;
      bus.MEM_ready = 1'b0;
      bus.OpCode    = '0;
      bus.ALU_zero  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      phase = "reset_state";
      step(1'b0, 1'b0, zero_v);
      check_lit("reset_fault", int'(bus.fault), 0);
      phase = "idle_start";
      step(1'b0, 1'b1, zero_v);

      s = busy_cycles;
      instr(6'h08, 0, 0, 1'b1, 1'b0, 4);
      check_lit("addi_regwrite_cycle", regwr_at - s, 4);
      instr(6'h23, 0, 3, 1'b1, 1'b0, 8);
      bus.ALU_zero = 1'b1;
      instr(6'h04, 0, 0, 1'b1, 1'b0, 3);
      bus.ALU_zero = 1'b0;
      instr(6'h02, 0, 0, 1'b1, 1'b0, 3);
      // Fetch ready lands on the expiring cycle; run dropped from EXEC onward.
      instr(6'h00, TO - 1, 0, 1'b0, 1'b0, 7);
      phase = "idle_after_r";
      repeat (2) step(1'b1, 1'b0, zero_v);

      step(1'b0, 1'b1, zero_v);
      instr(6'h2B, 0, 0, 1'b1, 1'b1, 0);
      phase = "idle_after_rst";
      step(1'b0, 1'b0, zero_v);

      step(1'b0, 1'b1, zero_v);
      instr(6'h2B, 1, 1, 1'b1, 1'b0, 6);
      instr(6'h3F, 0, 0, 1'b1, 1'b0, 0);
      hard_reset();
      check_lit("fault_cleared", int'(bus.fault), 0);

      phase = "fetch_timeout";
      step(1'b0, 1'b1, zero_v);
      e = '0; e.busy = 1'b1; e.mrd = 1'b1; e.srcb = 2'b01;
      repeat (TO) step(1'b0, 1'b1, e);
      e = '0; e.flt = 2'b10;
      repeat (3) step(1'b1, 1'b1, e);
      check_lit("timeout_fault_code", int'(bus.fault), 2);
      hard_reset();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
